// File: rtl/adc_multi_capture_if.sv
// adc_multi_capture_if: tagged sample stream between the capture block and its consumer
// Signals: m_data (sample), m_chan (channel index), m_or (overrange), m_last (last word of a set),
//          m_valid/m_ready (handshake). master drives the word, slave drives m_ready.
interface adc_multi_capture_if #(
    parameter int P_DATA_WIDTH = 14
);
    logic [P_DATA_WIDTH-1:0] m_data;
    logic [7:0]              m_chan;
    logic                    m_or;
    logic                    m_last;
    logic                    m_valid;
    logic                    m_ready;
    modport master (output m_data, m_chan, m_or, m_last, m_valid, input m_ready);
    modport slave (input m_data, m_chan, m_or, m_last, m_valid, output m_ready);
endinterface

// File: rtl/adc_multi_capture.sv
// adc_multi_capture: N-channel ADC capture with decimation, per-set channel serialisation and show-ahead output FIFO
// Optional feature macro: ADC_TEST_PATTERN_EN (adds test_mode input; snapshots become a ramp pattern)
// Ports: clk, reset (asynchronous, active-high)
//        enable, ch_mask, decim  - capture run control, channel enables, keep 1 of decim+1 sets
//        adc_d, adc_or           - live samples (channel k at [k*W +: W]) and overrange flags
//        m                       - tagged output stream (master side of adc_multi_capture_if)
//        overflow, drop_count    - sticky FIFO-loss flag and saturating loss counter
//        clear_status            - synchronous clear of overflow and drop_count
module adc_multi_capture #(
    parameter int P_CHANNELS    = 2,
    parameter int P_DATA_WIDTH  = 14,
    parameter int P_FIFO_DEPTH  = 16,
    parameter int P_DECIM_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [P_CHANNELS-1:0]              ch_mask,
    input  logic [P_DECIM_WIDTH-1:0]           decim,
    input  logic [P_CHANNELS*P_DATA_WIDTH-1:0] adc_d,
    input  logic [P_CHANNELS-1:0]              adc_or,
`ifdef ADC_TEST_PATTERN_EN
    input  logic                               test_mode,
`endif
    input  logic                               clear_status,
    output logic                               overflow,
    output logic [15:0]                        drop_count,
    adc_multi_capture_if.master                m
);
    localparam int W  = P_DATA_WIDTH;
    localparam int N  = P_CHANNELS;
    localparam int AW = $clog2(P_FIFO_DEPTH);
    localparam int FW = W + 10;
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state_q, state_d;
    logic [P_DECIM_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [N-1:0] rem_q, rem_d, or_q, rem_rest, snap_or;
    logic [N*W-1:0] data_q, snap_d;
    logic tick, final_cyc, accept, drop_set, push, sel_or;
    logic [7:0] sel;
    logic [W-1:0] sel_d;
    logic stg_v_q;
    logic [FW-1:0] stg_w_q;
    logic [FW-1:0] mem [P_FIFO_DEPTH];
    logic [AW:0] wp_q, rp_q;
    logic empty, full, pop, wr, lost;
    logic ovf_q;
    logic [15:0] drop_q;
    logic [16:0] dsum;
`ifdef ADC_TEST_PATTERN_EN
    logic [W-1:0] ramp_q;
`endif
    assign tick      = enable && dcnt_q == '0;
    assign rem_rest  = rem_q & (rem_q - N'(1));
    assign final_cyc = state_q == SCAN && rem_rest == '0;
    // A tick during the last scan cycle is accepted: the new set starts right behind it.
    assign accept    = tick && (state_q == IDLE || final_cyc);
    assign drop_set  = tick && !accept;
    assign dcnt_d    = !enable ? '0 : (dcnt_q >= decim ? '0 : dcnt_q + P_DECIM_WIDTH'(1));
    always_comb begin
        snap_d  = adc_d;
        snap_or = adc_or;
`ifdef ADC_TEST_PATTERN_EN
        if (test_mode) begin
            snap_or = '0;
            for (int k = 0; k < N; k++) snap_d[k*W +: W] = ramp_q + W'(k);
        end
`endif
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = accept ? (ch_mask != '0 ? SCAN : IDLE) : (state_q == SCAN && !final_cyc ? SCAN : IDLE);
    end
    // Lowest remaining mask bit is the channel emitted this cycle.
    always_comb begin
        sel    = '0;
        sel_d  = '0;
        sel_or = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rem_q[k]) begin
                sel    = 8'(k);
                sel_d  = data_q[k*W +: W];
                sel_or = or_q[k];
            end
        end
        push  = state_q == SCAN;
        rem_d = accept ? ch_mask : rem_rest;
    end
    assign empty = wp_q == rp_q;
    assign full  = (wp_q - rp_q) == (AW+1)'(P_FIFO_DEPTH);
    assign pop   = m.m_valid && m.m_ready;
    assign wr    = stg_v_q && (!full || pop);
    assign lost  = stg_v_q && !wr;
    assign dsum  = {1'b0, drop_q} + 17'(drop_set) + 17'(lost);
    assign m.m_valid = !empty;
    assign {m.m_last, m.m_or, m.m_chan, m.m_data} = empty ? '0 : mem[rp_q[AW-1:0]];
    assign overflow   = ovf_q;
    assign drop_count = drop_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            or_q    <= '0;
            stg_v_q <= 1'b0;
            stg_w_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            dcnt_q  <= dcnt_d;
            rem_q   <= rem_d;
            if (accept) begin
                data_q <= snap_d;
                or_q   <= snap_or;
            end
            // One register stage between the scan and the FIFO write.
            stg_v_q <= push;
            stg_w_q <= {final_cyc, sel_or, sel, sel_d};
            if (wr)  wp_q <= wp_q + (AW+1)'(1);
            if (pop) rp_q <= rp_q + (AW+1)'(1);
            ovf_q  <= clear_status ? 1'b0 : (ovf_q | lost);
            drop_q <= clear_status ? '0 : (dsum[16] ? 16'hFFFF : dsum[15:0]);
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wp_q[AW-1:0]] <= stg_w_q;
    end
`ifdef ADC_TEST_PATTERN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  ramp_q <= '0;
        else if (tick && test_mode) ramp_q <= ramp_q + W'(1);
    end
`endif
endmodule

// File: tb/tb_adc_multi_capture.sv
// tb_adc_multi_capture: directed self-checking bench for adc_multi_capture (4 channels, 4-word FIFO)
module tb_adc_multi_capture;
    localparam int N  = 4;
    localparam int W  = 14;
    localparam int D  = 4;
    localparam int DW = 16;
    logic clk = 1'b0;
    logic reset, enable, clear_status;
    logic [N-1:0] ch_mask, adc_or;
    logic [DW-1:0] decim;
    logic [N*W-1:0] adc_d;
    logic overflow;
    logic [15:0] drop_count;
`ifdef ADC_TEST_PATTERN_EN
    logic test_mode;
`endif
    int errors = 0;
    int checks = 0;
    logic [W+9:0] got [$];
    adc_multi_capture_if #(.P_DATA_WIDTH(W)) bus ();
    adc_multi_capture #(
        .P_CHANNELS(N), .P_DATA_WIDTH(W), .P_FIFO_DEPTH(D), .P_DECIM_WIDTH(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .ch_mask(ch_mask),
        .decim(decim),
        .adc_d(adc_d),
        .adc_or(adc_or),
`ifdef ADC_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .clear_status(clear_status),
        .overflow(overflow),
        .drop_count(drop_count),
        .m(bus.master)
    );
    always #5 clk = ~clk;
    // Words are recorded on the falling edge; the pop happens at the next rising edge.
    always @(negedge clk) if (bus.m_valid && bus.m_ready) got.push_back({bus.m_last, bus.m_or, bus.m_chan, bus.m_data});
    function automatic logic [W+9:0] wd(input logic l, input logic o, input int c, input int d);
        return {l, o, 8'(c), W'(d)};
    endfunction
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic set_data(input int base);
        for (int k = 0; k < N; k++) adc_d[k*W +: W] = W'(base + k);
    endtask
    task automatic clear_stat();
        clear_status = 1'b1;
        step(1);
        clear_status = 1'b0;
    endtask
    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; clear_status = 1'b0; ch_mask = '0; adc_or = '0; decim = '0;
        bus.m_ready = 1'b0;
        set_data(0);
`ifdef ADC_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        #1;
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.m_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        checks++; if ({bus.m_last, bus.m_or, bus.m_chan, bus.m_data} !== '0) begin
            errors++; $display("FAIL reset_word: got %h want 0", {bus.m_last, bus.m_or, bus.m_chan, bus.m_data});
        end
        step(2);
        reset = 1'b0;
    endtask
    task automatic test_basic();
        logic [W+9:0] e;
        int ch [3] = '{0, 1, 3};
        got.delete();
        bus.m_ready = 1'b1; ch_mask = 4'b1011; decim = 16'd3; set_data(100);
        enable = 1'b1;
        step(2);
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", bus.m_valid); end
        step(1);
        checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL basic_first_valid: got %b want 1", bus.m_valid); end
        checks++; if ({bus.m_chan, bus.m_data} !== {8'd0, 14'd100}) begin
            errors++; $display("FAIL basic_first_word: got chan %0d data %0d want chan 0 data 100", bus.m_chan, bus.m_data);
        end
        step(10);
        enable = 1'b0;
        step(8);
        checks++; if (got.size() != 12) begin errors++; $display("FAIL basic_count: got %0d want 12", got.size()); end
        for (int i = 0; i < 12; i++) begin
            e = wd(i % 3 == 2, 1'b0, ch[i%3], 100 + ch[i%3]);
            checks++;
            if (i >= got.size() || got[i] !== e) begin
                errors++; $display("FAIL basic_word%0d: got %h want %h", i, i < got.size() ? got[i] : '0, e);
            end
        end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL basic_drop: got %0d want 0", drop_count); end
    endtask
    task automatic test_drop();
        logic [W+9:0] e;
        got.delete();
        ch_mask = 4'b1111; decim = 16'd1; set_data(300);
        enable = 1'b1;
        step(20);
        enable = 1'b0;
        step(12);
        checks++; if (drop_count !== 16'd5) begin errors++; $display("FAIL drop_count: got %0d want 5", drop_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL drop_overflow: got %b want 0", overflow); end
        checks++; if (got.size() != 20) begin errors++; $display("FAIL drop_words: got %0d want 20", got.size()); end
        for (int i = 0; i < 20; i++) begin
            e = wd(i % 4 == 3, 1'b0, i % 4, 300 + i % 4);
            checks++;
            if (i >= got.size() || got[i] !== e) begin
                errors++; $display("FAIL drop_word%0d: got %h want %h", i, i < got.size() ? got[i] : '0, e);
            end
        end
        clear_stat();
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL drop_clear: got %0d want 0", drop_count); end
    endtask
    task automatic test_full();
        int bad = 0;
        got.delete();
        bus.m_ready = 1'b0; ch_mask = 4'b0011; decim = 16'd7; set_data(100);
        enable = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step(1);
            if (bus.m_valid && {bus.m_chan, bus.m_data} !== {8'd0, 14'd100}) bad++;
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if ({bus.m_chan, bus.m_data} !== {8'd0, 14'd100}) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_stable: got %0d unstable samples want 0", bad); end
        checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", bus.m_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b want 1", overflow); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL full_drop: got %0d want 2", drop_count); end
        set_data(500); ch_mask = 4'b0001;
        enable = 1'b1;
        step(1);
        enable = 1'b0;
        step(1);
        bus.m_ready = 1'b1;
        step(7);
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL full_popush_drop: got %0d want 2", drop_count); end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL full_words: got %0d want 5", got.size()); end
        checks++; if (got.size() < 5 || got[0] !== wd(0, 0, 0, 100) || got[1] !== wd(1, 0, 1, 101) || got[4] !== wd(1, 0, 0, 500)) begin
            errors++; $display("FAIL full_content: got %h %h %h want %h %h %h",
                got.size() > 0 ? got[0] : '0, got.size() > 1 ? got[1] : '0, got.size() > 4 ? got[4] : '0,
                wd(0, 0, 0, 100), wd(1, 0, 1, 101), wd(1, 0, 0, 500));
        end
        clear_stat();
        checks++; if ({overflow, drop_count} !== 17'd0) begin errors++; $display("FAIL full_clear: got %b/%0d want 0/0", overflow, drop_count); end
    endtask
    task automatic test_overrange();
        int n_or = 0;
        got.delete();
        bus.m_ready = 1'b1; ch_mask = 4'b1111; decim = 16'd3; set_data(700); adc_or = 4'b0100;
        enable = 1'b1;
        step(1);
        adc_or = 4'b0000;
        step(8);
        enable = 1'b0;
        step(10);
        foreach (got[i]) if (got[i][W+8]) n_or++;
        checks++; if (got.size() != 12) begin errors++; $display("FAIL or_words: got %0d want 12", got.size()); end
        checks++; if (n_or != 1) begin errors++; $display("FAIL or_count: got %0d want 1", n_or); end
        checks++; if (got.size() < 3 || got[2] !== wd(0, 1, 2, 702)) begin
            errors++; $display("FAIL or_word: got %h want %h", got.size() > 2 ? got[2] : '0, wd(0, 1, 2, 702));
        end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL or_drop: got %0d want 0", drop_count); end
    endtask
    task automatic test_reset_mid();
        got.delete();
        bus.m_ready = 1'b0; ch_mask = 4'b1111; decim = 16'd15; set_data(100);
        enable = 1'b1;
        step(4);
        checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", bus.m_valid); end
        reset = 1'b1;
        #1;
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", bus.m_valid); end
        set_data(200);
        bus.m_ready = 1'b1;
        #1;
        reset = 1'b0;
        step(1);
        enable = 1'b0;
        step(8);
        checks++; if (got.size() != 4) begin errors++; $display("FAIL mid_words: got %0d want 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== wd(i == 3, 0, i, 200 + i)) begin
                errors++; $display("FAIL mid_word%0d: got %h want %h", i, i < got.size() ? got[i] : '0, wd(i == 3, 0, i, 200 + i));
            end
        end
    endtask
`ifdef ADC_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [W+9:0] e [6];
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        got.delete();
        test_mode = 1'b1; ch_mask = 4'b0000; decim = 16'd0; bus.m_ready = 1'b1;
        enable = 1'b1;
        step(16382);
        enable = 1'b0;
        step(2);
        ch_mask = 4'b0101; decim = 16'd3; adc_or = 4'b1111; set_data(100);
        enable = 1'b1;
        step(9);
        enable = 1'b0;
        step(10);
        e = '{wd(0, 0, 0, 16382), wd(1, 0, 2, 0), wd(0, 0, 0, 16383), wd(1, 0, 2, 1), wd(0, 0, 0, 0), wd(1, 0, 2, 2)};
        checks++; if (got.size() != 6) begin errors++; $display("FAIL pat_words: got %0d want 6", got.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== e[i]) begin
                errors++; $display("FAIL pat_word%0d: got %h want %h", i, i < got.size() ? got[i] : '0, e[i]);
            end
        end
        test_mode = 1'b0; adc_or = '0;
    endtask
`endif
    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_full();
        test_overrange();
        test_reset_mid();
`ifdef ADC_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adc_multi_capture.md
Name: adc_multi_capture

Overview:
Parametrised successor to the per-ADC interface controller. It takes N parallel ADC sample buses, already synchronous to clk, and applies common decimation. Each retained sample set is serialised, one enabled channel at a time, through an internal show-ahead FIFO onto a valid/ready stream with channel tags. It sits between the ADC pin interfaces and the HPS-side stream/DMA logic, and replaces one-instance-per-ADC wiring with a single N-channel block.

Parameters:
P_CHANNELS, 2, number of ADC channels (1..128)
P_DATA_WIDTH, 14, sample width per channel
P_FIFO_DEPTH, 16, output FIFO depth in words (power of 2, >=2)
P_DECIM_WIDTH, 16, width of the decimation control

Ports:
clk  in  1  system clock; ADC data is synchronous to it
reset  in  1  asynchronous, active-high reset
enable  in  1  capture run control
ch_mask  in  P_CHANNELS  per-channel enable; bit k = channel k
decim  in  P_DECIM_WIDTH  keep 1 of every decim+1 sample sets
adc_d  in  P_CHANNELS*P_DATA_WIDTH  channel k at [k*W +: W]
adc_or  in  P_CHANNELS  per-channel overrange flag
m_data  out  P_DATA_WIDTH  sample word
m_chan  out  8  channel index of m_data
m_or  out  1  overrange flag captured with m_data
m_last  out  1  word is the highest enabled channel of its set
m_valid  out  1  stream valid
m_ready  in  1  stream ready
overflow  out  1  sticky: a word was lost to FIFO full
drop_count  out  16  saturating count of lost words and sets
clear_status  in  1  synchronous clear of overflow and drop_count

Behaviour:
- Decimation counter dcnt:
  - While enable=0, dcnt=0.
  - While enable=1, dcnt counts 0..decim and wraps to 0.
  - A tick occurs on each clock edge with enable=1 and dcnt==0. The first enabled cycle therefore ticks.
  - decim=0 gives a tick every cycle.
- Snapshot: on a tick, adc_d, adc_or and ch_mask are latched into holding registers. Changes after the tick do not affect that set.
- FSM with two states, IDLE and SCAN:
  - IDLE -> SCAN on a tick with latched mask != 0. A tick with mask == 0 stays in IDLE and emits nothing.
  - In SCAN, one FIFO push per cycle, for enabled channels in ascending index order. Disabled channels are skipped with no cycle cost.
  - The push of the highest enabled channel sets m_last=1 on that word, and the FSM returns to IDLE in the same cycle.
  - Scan length = popcount(mask) cycles.
- Latency: tick at edge t -> first push at edge t+1 -> m_valid=1 after edge t+2 (FIFO empty, no backpressure).
- Tick while in SCAN, except on the final scan cycle: the new set is dropped whole and drop_count increments by 1. A tick on the final scan cycle is accepted.
- Drop-free requirement: decim+1 >= popcount(mask).
- enable deasserted mid-scan: the current scan completes. No new ticks occur.
- FIFO:
  - Show-ahead: m_valid = !empty. Pop on m_valid & m_ready.
  - m_data, m_chan, m_or and m_last hold stable while m_valid & !m_ready.
  - A push is accepted when count < P_FIFO_DEPTH, or when a pop occurs in the same cycle.
  - A rejected push loses only that word: overflow <= 1 and drop_count increments. The scan continues.
- drop_count saturates at 16'hFFFF. clear_status has priority over a same-cycle increment; the result is 0.
- Reset (asynchronous): state IDLE, dcnt=0, FIFO empty, holding registers 0, and every output 0.
  - m_valid deasserts immediately on reset assertion.
  - The first tick can occur on the first edge after reset release with enable=1.

Optional Feature:
ADC_TEST_PATTERN_EN:
- Defined: adds input port test_mode (1 bit) and an internal ramp register of P_DATA_WIDTH bits, reset to 0.
- When test_mode=1 at a tick, channel k's snapshot is (ramp + k) mod 2^P_DATA_WIDTH and its OR flag is 0. ramp increments by 1 on every tick while test_mode=1, including dropped sets.
- Not defined: the port and ramp do not exist, and live adc_d/adc_or are always captured.

Test Plan:
- P_CHANNELS=4, ch_mask=4'b1011, decim=3, m_ready=1, constant data ch k = 100+k -> repeating words (ch0,100), (ch1,101), (ch3,103,last=1) every 4 cycles; first m_valid 2 cycles after enable rises; drop_count=0.
- ch_mask=4'b1111, decim=1 -> every second set is dropped; after 10 ticks, drop_count=5 and 20 words are delivered.
- P_FIFO_DEPTH=4, m_ready=0, mask=4'b0011, decim=7, 3 ticks -> 4 words held, overflow=1, drop_count=2; m_data stable throughout. Then m_ready=1 with a push on a full FIFO in the same cycle as a pop -> push accepted, no new drop.
- adc_or[2]=1 on one tick only -> exactly one word with m_chan=2 and m_or=1.
- Reset asserted mid-scan with 2 words in the FIFO -> m_valid=0 immediately; after release, output resumes with a fresh set and no stale words.
- ADC_TEST_PATTERN_EN defined, test_mode=1, mask=4'b0101, decim=3 -> tick n yields ch0=n and ch2=n+2, wrapping 16383 -> 0 at W=14.
